// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared segment patterns, reader FSM encoding and digit helpers.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  localparam int DIGITS = 4;

  // Active-low segment patterns, bit6..bit0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_9_ALT = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_one_cold(input logic [DIGITS-1:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic logic [1:0] cold_index(input logic [DIGITS-1:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_reader_if
// Purpose  : Multiplexed display bus plus the reader's decoded read-back.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_reader_if;
  import seven_seg_pkg::*;

  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   valid;
  logic                frame_done;
  logic [7:0]          err_cnt;

  modport master (
    output an, seg,
    input  digits, valid, frame_done, err_cnt
  );

  modport slave (
    input  an, seg,
    output digits, valid, frame_done, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/seven_segment_decode.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_decode
// Purpose  : Combinational active-low segment pattern to hex nibble decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:            nibble = 4'h0;
      SEG_1:            nibble = 4'h1;
      SEG_2:            nibble = 4'h2;
      SEG_3:            nibble = 4'h3;
      SEG_4:            nibble = 4'h4;
      SEG_5:            nibble = 4'h5;
      SEG_6:            nibble = 4'h6;
      SEG_7:            nibble = 4'h7;
      SEG_8:            nibble = 4'h8;
      SEG_9, SEG_9_ALT: nibble = 4'h9;
      SEG_A:            nibble = 4'hA;
      SEG_B:            nibble = 4'hB;
      SEG_C:            nibble = 4'hC;
      SEG_D:            nibble = 4'hD;
      SEG_E:            nibble = 4'hE;
      SEG_F:            nibble = 4'hF;
      default:          legal  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Captures stable digits from a multiplexed 7-segment bus.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  seven_segment_reader_if.slave  bus
);

  localparam logic [7:0] c_last_cnt = 8'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0]   r_an_q;
  logic [6:0]          r_seg_q;
  logic [DIGITS-1:0]   r_an_p;
  logic [6:0]          r_seg_p;
  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_seen;
  logic                r_frame_done;
  logic [7:0]          r_err_cnt;

  logic                w_same;
  logic                w_cold;
  logic [1:0]          w_idx;
  logic [DIGITS-1:0]   w_bit;
  logic [DIGITS-1:0]   w_seen_next;
  logic                w_legal;
  logic [3:0]          w_nibble;

  seven_segment_decode u_decode (
    .seg    (r_seg_q),
    .legal  (w_legal),
    .nibble (w_nibble)
  );

  assign w_same      = ({r_an_q, r_seg_q} == {r_an_p, r_seg_p});
  assign w_cold      = is_one_cold(r_an_q);
  assign w_idx       = cold_index(r_an_q);
  assign w_bit       = 4'b0001 << w_idx;
  assign w_seen_next = r_seen | w_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_q       <= 4'hF;
      r_seg_q      <= 7'h7F;
      r_an_p       <= 4'hF;
      r_seg_p      <= 7'h7F;
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_digits     <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_an_q       <= bus.an;
      r_seg_q      <= bus.seg;
      r_an_p       <= r_an_q;
      r_seg_p      <= r_seg_q;
      r_frame_done <= 1'b0;

      if (!w_cold) begin
        r_state <= IDLE;
        r_cnt   <= 8'd0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= TRACK;
            r_cnt   <= 8'd1;
          end
          TRACK: begin
            if (!w_same) begin
              r_cnt <= 8'd1;
            end else if (r_cnt == c_last_cnt) begin
              // Sample count reaches STABLE_CYCLES here: capture this edge.
              r_state <= HOLD;
              r_cnt   <= r_cnt + 8'd1;
              if (w_legal) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_nibble;
                r_valid[w_idx]                <= 1'b1;
              end else begin
                r_valid[w_idx] <= 1'b0;
                if (r_err_cnt != 8'hFF)
                  r_err_cnt <= r_err_cnt + 8'd1;
              end
              if (w_seen_next == 4'hF) begin
                r_seen       <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_seen <= w_seen_next;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          HOLD: begin
            if (!w_same) begin
              r_state <= TRACK;
              r_cnt   <= 8'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.digits     = r_digits;
  assign bus.valid      = r_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/seven_segment_reader.md
# seven_segment_reader

Receive-side counterpart of the seven_segment_display encoder. It watches a time-multiplexed 4-digit, active-low seven-segment bus (shared segment lines, per-digit anode enables) and waits for each digit's pattern to be stable. It then decodes the pattern back to a hex nibble and stores it per digit. It sits in self-check and loopback paths, letting the board or bench read back what a display driver is actually putting out.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 2..255)
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- an  input  4  digit enables, active-low; exactly one bit low selects digit index of that bit
- seg  input  7  segment lines, active-low, bit6..bit0 = g,f,e,d,c,b,a
- digits  output  16  decoded nibbles; digit i at [4i+3:4i]
- valid  output  4  valid[i]=1 when digits[i] holds a legal decode
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse
- err_cnt  output  8  saturating count of captures with an undecodable pattern

## Operation
- Inputs are registered once into an_q/seg_q. All decisions use the registered values.
- Decode, seg as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010
  - 6=0000010, 7=1111000, 8=0000000
  - 9=0011000 or 0010000
  - A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
  - Any other pattern is illegal.
- 0000011 always decodes to B. It never decodes to 6.
- FSM states:
  - IDLE: an_q is not one-cold, i.e. it is 1111 or has two or more bits low. The stability counter is held at 0.
  - TRACK: an_q is one-cold. The counter increments while (an_q, seg_q) equals the previous sample. On any change the counter reloads to 1, still in TRACK. When the counter reaches STABLE_CYCLES, the block performs a capture and moves to HOLD.
  - HOLD: no further captures. Any change in (an_q, seg_q) moves to TRACK with the counter at 1, or to IDLE if an_q is no longer one-cold.
  - From any state, an_q becoming non-one-cold moves to IDLE.
- Capture of digit i:
  - Legal pattern: digits[i] is set to the decoded value and valid[i] to 1.
  - Illegal pattern: digits[i] is unchanged, valid[i] is set to 0, and err_cnt is incremented. err_cnt holds at 255.
  - seen[i] is set.
- When the capture sets the last clear bit of seen, frame_done pulses in the same cycle the capture becomes visible on the outputs. seen is cleared on that edge.
- A re-capture of an already-seen digit updates that digit. It does not advance the frame.

## Timing
- Reset values: digits=0, valid=0, frame_done=0, err_cnt=0, seen=0, FSM=IDLE, counter=0, an_q=1111, seg_q=1111111.
- Latency: a pair first present at rising edge k, and held through edge k+STABLE_CYCLES-1, is registered at edges k..k+STABLE_CYCLES-1. Outputs update at edge k+STABLE_CYCLES.
- A glitch of a single sample restarts the count. A pair that is stable for STABLE_CYCLES-1 samples is never captured.
- Reset asserted mid-frame clears everything immediately. No frame_done pulse occurs on reset or in the first cycle after release.
- frame_done is never high for two consecutive cycles.

## Structure
- Shared package seven_seg_pkg holds:
  - segment pattern constants SEG_0..SEG_F and SEG_9_ALT
  - the FSM state encoding (IDLE, TRACK, HOLD)
  - the DIGITS=4 constant
- The encoder and reader share the pattern constants so they cannot drift.
- One sub-module, seven_segment_decode: purely combinational, seg[6:0] -> {legal, nibble[3:0]}. Instantiated once.

## Test plan
- Decode sweep: STABLE_CYCLES=4. Drive an=1110 with each of the 16 legal patterns, 6 cycles each. Required: digits[3:0] equals 0..F after 4 cycles, valid[0]=1, 0000011 -> B, and 0010000 -> 9.
- Stability: drive an=1101, seg=0110000 for 3 cycles, then 0100100 for 4 cycles. Required: no capture from the first pattern; digits[7:4]=2 at edge 4 after the change.
- Frame: scan digits 0..3 with patterns 1,2,3,4, 5 cycles each. Required: frame_done exactly once, coincident with digit 3's capture; digits=16'h4321 and valid=1111.
- Illegal pattern and anode faults: seg=1111111 on digit 2 -> valid[2]=0, digits[11:8] retained, err_cnt=1. Then an=1100 -> no capture. Then 300 illegal captures -> err_cnt=255.
- Reset mid-frame: capture digits 0 and 1, then pulse rst asynchronously between clock edges. Required: all outputs 0 immediately. A following full scan gives exactly one frame_done.
